// File: rtl/soc_new_oci_pkg.sv
// Shared OCI trace definitions: DCT entry geometry, branch code encodings and the frame record.
package soc_new_oci_pkg;

    localparam int DCT_ENTRY_W = 2;
    localparam int DCT_DEPTH   = 15;
    localparam int DCT_CNT_W   = 4;
    localparam int DCT_BUF_W   = DCT_ENTRY_W * DCT_DEPTH;

    localparam logic [DCT_ENTRY_W-1:0] DCT_NONE = 2'b00;
    localparam logic [DCT_ENTRY_W-1:0] DCT_NT   = 2'b01;
    localparam logic [DCT_ENTRY_W-1:0] DCT_TK   = 2'b10;
    localparam logic [DCT_ENTRY_W-1:0] DCT_RET  = 2'b11;

    typedef struct packed {
        logic [DCT_BUF_W-1:0] buffer;
        logic [DCT_CNT_W-1:0] count;
    } dct_frame_t;

endpackage

// File: rtl/soc_new_dct_frame_reg.sv
// Output holding register for completed DCT frames; optional timestamp latch under
// SOC_NEW_DCT_PACKER_TIMESTAMP_EN.
module soc_new_dct_frame_reg
    import soc_new_oci_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [DCT_BUF_W-1:0] load_buffer,
    input  logic [DCT_CNT_W-1:0] load_count,
    input  logic                 frame_ready,
    output logic                 frame_valid,
    output logic [DCT_BUF_W-1:0] frame_buffer,
    output logic [DCT_CNT_W-1:0] frame_count
`ifdef SOC_NEW_DCT_PACKER_TIMESTAMP_EN
    ,
    output logic [15:0]          frame_timestamp
`endif
);

    // Handshake: a frame transfers on any edge where frame_valid && frame_ready; while
    // frame_valid && !frame_ready all frame_* outputs hold. The producer only asserts load
    // when the register is empty or draining, so a load may replace a departing frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_valid  <= 1'b0;
            frame_buffer <= '0;
            frame_count  <= '0;
        end else if (load) begin
            frame_valid  <= 1'b1;
            frame_buffer <= load_buffer;
            frame_count  <= load_count;
        end else if (frame_valid && frame_ready) begin
            frame_valid  <= 1'b0;
        end
    end

`ifdef SOC_NEW_DCT_PACKER_TIMESTAMP_EN
    logic [15:0] cycle_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt       <= '0;
            frame_timestamp <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
            if (load) frame_timestamp <= cycle_cnt;
        end
    end
`endif

endmodule

// File: rtl/soc_new_cpu_oci_dct_packer.sv
// DCT trace producer: packs 2-bit branch codes into 15-entry frames for the trace FIFO.
// Optional frame_timestamp output under SOC_NEW_DCT_PACKER_TIMESTAMP_EN.
module soc_new_cpu_oci_dct_packer
    import soc_new_oci_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   trace_en,
    input  logic                   dct_in_valid,
    input  logic [DCT_ENTRY_W-1:0] dct_in_code,
    input  logic                   flush,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic [DCT_BUF_W-1:0]   frame_buffer,
    output logic [DCT_CNT_W-1:0]   frame_count,
    output logic [DCT_BUF_W-1:0]   dct_buffer,
    output logic [DCT_CNT_W-1:0]   dct_count,
    output logic                   overflow
`ifdef SOC_NEW_DCT_PACKER_TIMESTAMP_EN
    ,
    output logic [15:0]            frame_timestamp
`endif
);

    localparam logic [DCT_CNT_W-1:0] FULL_CNT = DCT_CNT_W'(DCT_DEPTH);

    logic       code_valid;
    logic       buf_full;
    logic       accept;
    logic       drop;
    logic       flush_pend;
    logic       close_req;
    logic       out_free;
    logic       do_load;
    dct_frame_t post;

    assign code_valid = trace_en && dct_in_valid && (dct_in_code != DCT_NONE);
    assign buf_full   = (dct_count == FULL_CNT);
    assign accept     = code_valid && !buf_full;
    assign drop       = code_valid && buf_full;

    // Post-accept view of the live buffer; a close captures this, so the entry that
    // completes a frame (or arrives with a flush) lands in the frame, not the next one.
    assign post.buffer = accept ? {dct_buffer[DCT_BUF_W-DCT_ENTRY_W-1:0], dct_in_code}
                                : dct_buffer;
    assign post.count  = accept ? dct_count + 1'b1 : dct_count;

    // A blocked flush is remembered so the partial frame closes as soon as the output frees.
    assign close_req = (post.count == FULL_CNT) ||
                       ((flush || flush_pend) && (post.count != '0));
    assign out_free  = !frame_valid || frame_ready;
    assign do_load   = close_req && out_free;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dct_buffer <= '0;
            dct_count  <= '0;
            flush_pend <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (do_load) begin
                dct_buffer <= '0;
                dct_count  <= '0;
                flush_pend <= 1'b0;
            end else begin
                dct_buffer <= post.buffer;
                dct_count  <= post.count;
                if (flush && (post.count != '0)) flush_pend <= 1'b1;
            end
            if (drop) overflow <= 1'b1;
        end
    end

    soc_new_dct_frame_reg u_frame_reg (
        .clk             (clk),
        .reset_n         (reset_n),
        .load            (do_load),
        .load_buffer     (post.buffer),
        .load_count      (post.count),
        .frame_ready     (frame_ready),
        .frame_valid     (frame_valid),
        .frame_buffer    (frame_buffer),
        .frame_count     (frame_count)
`ifdef SOC_NEW_DCT_PACKER_TIMESTAMP_EN
        ,
        .frame_timestamp (frame_timestamp)
`endif
    );

endmodule

// File: tb/tb_soc_new_cpu_oci_dct_packer.sv
// Self-checking bench for soc_new_cpu_oci_dct_packer: directed frame scenarios plus random traffic
// against a queue-based reference model.
module tb_soc_new_cpu_oci_dct_packer;

    logic        clk;
    logic        reset_n;
    logic        trace_en;
    logic        dct_in_valid;
    logic [1:0]  dct_in_code;
    logic        flush;
    logic        frame_valid;
    logic        frame_ready;
    logic [29:0] frame_buffer;
    logic [3:0]  frame_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;

    soc_new_cpu_oci_dct_packer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .trace_en     (trace_en),
        .dct_in_valid (dct_in_valid),
        .dct_in_code  (dct_in_code),
        .flush        (flush),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_buffer (frame_buffer),
        .frame_count  (frame_count),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .overflow     (overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int dut_xfer = 0;

    // reference model: live entries oldest-first, plus the held output frame
    int          live_q[$];
    logic        m_fv;
    logic [29:0] m_fbuf;
    logic [3:0]  m_fcnt;
    logic        m_ovf;
    logic        m_pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Oldest entry ends in the most significant occupied slot: base-4 positional value.
    function automatic logic [29:0] pack(input int q[$]);
        logic [29:0] v = '0;
        foreach (q[i]) v = v * 4 + 30'(q[i]);
        return v;
    endfunction

    task automatic model_reset();
        live_q.delete();
        m_fv = 1'b0; m_fbuf = '0; m_fcnt = '0; m_ovf = 1'b0; m_pend = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic vld, input logic [1:0] code,
                              input logic fl, input logic rdy);
        int   post_q[$];
        logic cv, acc, want, free;
        cv  = en && vld && (code != 2'b00);
        acc = cv && (live_q.size() < 15);
        if (cv && !acc) m_ovf = 1'b1;
        post_q = live_q;
        if (acc) post_q.push_back(int'(code));
        free = !m_fv || rdy;
        want = (post_q.size() == 15) || ((fl || m_pend) && (post_q.size() > 0));
        if (want && free) begin
            m_fv   = 1'b1;
            m_fbuf = pack(post_q);
            m_fcnt = 4'(post_q.size());
            live_q.delete();
            m_pend = 1'b0;
        end else begin
            if (m_fv && rdy) m_fv = 1'b0;
            live_q = post_q;
            if (fl && (post_q.size() > 0)) m_pend = 1'b1;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".frame_valid"},  32'(frame_valid),  32'(m_fv));
        check({tag, ".frame_buffer"}, 32'(frame_buffer), 32'(m_fbuf));
        check({tag, ".frame_count"},  32'(frame_count),  32'(m_fcnt));
        check({tag, ".dct_buffer"},   32'(dct_buffer),   32'(pack(live_q)));
        check({tag, ".dct_count"},    32'(dct_count),    32'(live_q.size()));
        check({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
    endtask

    // driver: called at a negedge, applies inputs for one clock, compares at next negedge
    task automatic step(input string tag, input logic en, input logic vld,
                        input logic [1:0] code, input logic fl, input logic rdy);
        trace_en = en; dct_in_valid = vld; dct_in_code = code; flush = fl; frame_ready = rdy;
        if (frame_valid && rdy) dut_xfer++;
        model_step(en, vld, code, fl, rdy);
        @(posedge clk);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        compare_all("reset");
    endtask

    function automatic logic [1:0] rcode();
        return 2'($urandom_range(1, 3));
    endfunction

    int x0;

    initial begin
        reset_n = 1'b0; trace_en = 1'b0; dct_in_valid = 1'b0; dct_in_code = 2'b00;
        flush = 1'b0; frame_ready = 1'b1;
        model_reset();
        do_reset();

        // full frame of taken branches
        for (int i = 0; i < 15; i++) step("full15", 1, 1, 2'b10, 0, 1);
        check("full15_fv",  32'(frame_valid),  32'd1);
        check("full15_buf", 32'(frame_buffer), 32'h2AAAAAAA);
        check("full15_cnt", 32'(frame_count),  32'd15);
        check("full15_dct", 32'(dct_count),    32'd0);

        // partial frame closed by flush, then a flush with nothing buffered
        step("part", 1, 1, 2'b01, 0, 1);
        step("part", 1, 1, 2'b10, 0, 1);
        step("part", 1, 1, 2'b11, 0, 1);
        step("part", 1, 0, 2'b00, 1, 1);
        check("part_buf", 32'(frame_buffer), 32'h0000001B);
        check("part_cnt", 32'(frame_count),  32'd3);
        step("empty_flush", 1, 0, 2'b00, 1, 1);
        check("empty_flush_fv", 32'(frame_valid), 32'd0);

        // 15th entry with flush in the same cycle closes exactly one frame
        for (int i = 0; i < 14; i++) step("f15", 1, 1, rcode(), 0, 1);
        x0 = dut_xfer;
        step("f15", 1, 1, rcode(), 1, 1);
        check("f15_cnt", 32'(frame_count), 32'd15);
        check("f15_dct", 32'(dct_count),   32'd0);
        step("f15", 0, 0, 2'b00, 0, 1);
        step("f15", 0, 0, 2'b00, 0, 1);
        check("f15_fv",   32'(frame_valid),    32'd0);
        check("f15_xfer", 32'(dut_xfer - x0),  32'd1);

        // reserved code and disabled trace never count
        for (int i = 0; i < 5; i++) step("ign_pre", 1, 1, rcode(), 0, 1);
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 0) step("ign", 1, 1, 2'b00, 0, 1);
            else                           step("ign", 0, 1, rcode(), 0, 1);
            check("ign_dct", 32'(dct_count), 32'd5);
        end
        step("ign_flush", 0, 0, 2'b00, 1, 1);
        check("ign_flush_cnt", 32'(frame_count), 32'd5);
        step("ign_idle", 0, 0, 2'b00, 0, 1);

        // backpressure: two frames held, 31st accept dropped, then back-to-back drain
        for (int i = 0; i < 30; i++) step("bp", 1, 1, rcode(), 0, 0);
        check("bp_fv",  32'(frame_valid), 32'd1);
        check("bp_cnt", 32'(frame_count), 32'd15);
        check("bp_dct", 32'(dct_count),   32'd15);
        step("bp31", 1, 1, rcode(), 0, 0);
        check("bp31_ovf", 32'(overflow),  32'd1);
        check("bp31_dct", 32'(dct_count), 32'd15);
        x0 = dut_xfer;
        step("bp_drain", 0, 0, 2'b00, 0, 1);
        check("bp_drain1_fv",  32'(frame_valid), 32'd1);
        check("bp_drain1_dct", 32'(dct_count),   32'd0);
        step("bp_drain", 0, 0, 2'b00, 0, 1);
        check("bp_drain2_fv",  32'(frame_valid),   32'd0);
        check("bp_xfer",       32'(dut_xfer - x0), 32'd2);

        // reset mid-frame with a held frame and 7 live entries
        for (int i = 0; i < 22; i++) step("mid", 1, 1, rcode(), 0, 0);
        check("mid_dct", 32'(dct_count),   32'd7);
        check("mid_fv",  32'(frame_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_fv",   32'(frame_valid),  32'd0);
        check("arst_fbuf", 32'(frame_buffer), 32'd0);
        check("arst_fcnt", 32'(frame_count),  32'd0);
        check("arst_dbuf", 32'(dct_buffer),   32'd0);
        check("arst_dcnt", 32'(dct_count),    32'd0);
        check("arst_ovf",  32'(overflow),     32'd0);
        model_reset();
        frame_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        x0 = dut_xfer;
        step("post_rst", 0, 0, 2'b00, 0, 1);
        check("post_rst_xfer", 32'(dut_xfer - x0), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step("rand", $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
